// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller.
//   - scan_state_t : FSM state encoding (idle, dead-time blank, digit drive)
//   - SEG_BLANK    : segment pattern with every segment dark (active-low)
//   - AN_ON/AN_OFF : active-low anode polarity
//   - DP_ON/DP_OFF : active-low decimal-point polarity
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic AN_ON  = 1'b0;
  localparam logic AN_OFF = 1'b1;
  localparam logic DP_ON  = 1'b0;
  localparam logic DP_OFF = 1'b1;

endpackage

// File: rtl/BCD7Seg.sv
// BCD to 7-segment decoder, active-low segments ordered {g,f,e,d,c,b,a}.
// Nibbles above 9 decode to all segments dark.
//   bcd : 4-bit BCD digit
//   seg : 7-bit active-low segment pattern
module BCD7Seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    unique case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Holds a double-buffered BCD frame (pending + active), walks one digit per
// slot through a single shared decoder, and inserts a dead-time blank at the
// start of every slot to suppress ghosting.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : scan enable; low forces the display dark
//   load        : one-cycle strobe capturing bcd_in/dp_in into the pending buffer
//   bcd_in      : packed nibbles, digit 0 in bits [3:0]
//   dp_in       : decimal-point request per digit, active-high
//   lz_blank    : leading-zero blanking enable
//   seg, dp, an : registered active-low segment, decimal point, anode drive
//   frame_done  : one-cycle pulse on every frame boundary
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t             state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;

  logic [4*NUM_DIGITS-1:0] pend_bcd;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_valid;
  logic [4*NUM_DIGITS-1:0] act_bcd;
  logic [NUM_DIGITS-1:0]   act_dp;

  logic                    boundary;
  logic                    zero_above;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [6:0]              dec_seg;

  // A frame starts either when scanning resumes from idle or when the last
  // digit's slot ends; both are the only points where the active buffer moves.
  assign boundary = en && ((state == ST_IDLE) ||
                           (state == ST_DRIVE && cnt == SLOT_LAST && idx == IDX_LAST));

  // Digit k is a leading zero when it and every nibble above it are zero.
  // Digit 0 is always shown so a zero value still reads "0".
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (act_bcd[4*k +: 4] == 4'd0);
      lz_mask[k] = lz_blank && zero_above;
    end
  end

  // Select the current digit's nibble, decimal point, blank flag and anode.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_sel    = {NUM_DIGITS{AN_OFF}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib   = act_bcd[4*k +: 4];
        cur_dp    = act_dp[k];
        cur_blank = lz_mask[k];
        an_sel[k] = AN_ON;
      end
    end
  end

  BCD7Seg u_dec (
    .bcd (cur_nib),
    .seg (dec_seg)
  );

  // Pending/active frame buffers. A load landing on the boundary cycle is
  // forwarded straight to the active buffer so it is not delayed a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these buffers are ordinary flops with a defined power-up frame,
      // so they take the reset; a RAM-backed frame store would not.
      pend_bcd   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      act_bcd    <= '0;
      act_dp     <= '0;
    end else if (boundary) begin
      if (load) begin
        act_bcd    <= bcd_in;
        act_dp     <= dp_in;
        pend_valid <= 1'b0;
      end else if (pend_valid) begin
        act_bcd    <= pend_bcd;
        act_dp     <= pend_dp;
        pend_valid <= 1'b0;
      end
    end else if (load) begin
      pend_bcd   <= bcd_in;
      pend_dp    <= dp_in;
      pend_valid <= 1'b1;
    end
  end

  // Scan FSM. Outputs are registered alongside the state they belong to, so
  // the pins follow the state entered on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      idx        <= '0;
      an         <= {NUM_DIGITS{AN_OFF}};
      seg        <= SEG_BLANK;
      dp         <= DP_OFF;
      frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values; the dark defaults below are overridden when driving.
      frame_done <= boundary;
      an         <= {NUM_DIGITS{AN_OFF}};
      seg        <= SEG_BLANK;
      dp         <= DP_OFF;
      if (!en) begin
        state <= ST_IDLE;
        cnt   <= '0;
        idx   <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            state <= ST_BLANK;
            cnt   <= '0;
            idx   <= '0;
          end
          ST_BLANK: begin
            cnt <= cnt + 1'b1;
            if (cnt == BLANK_LAST) begin
              state <= ST_DRIVE;
              if (!cur_blank) begin
                an  <= an_sel;
                seg <= dec_seg;
                dp  <= cur_dp ? DP_ON : DP_OFF;
              end
            end
          end
          ST_DRIVE: begin
            if (cnt == SLOT_LAST) begin
              state <= ST_BLANK;
              cnt   <= '0;
              idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
              if (!cur_blank) begin
                an  <= an_sel;
                seg <= dec_seg;
                dp  <= cur_dp ? DP_ON : DP_OFF;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It holds a double-buffered BCD frame and walks one digit at a time through a single shared `BCD7Seg` decoder instance. It drives active-low anodes with a dead-time blank between digits to suppress ghosting. It sits between the datapath that produces BCD values and the board pins.

## Interface

Parameters:
- `NUM_DIGITS`, default 4: number of digits scanned, legal range 2–8.
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYCLES`, default 500: dead-time cycles at the start of each slot; 1 ≤ `BLANK_CYCLES` < `REFRESH_DIV`.

Ports:
- `clk` input, 1: single clock.
- `rst_n` input, 1: reset, asynchronous and active-low.
- `en` input, 1: scan enable; low forces the display dark.
- `load` input, 1: one-cycle strobe that captures `bcd_in` and `dp_in` into the pending buffer.
- `bcd_in` input, 4*NUM_DIGITS: packed nibbles; digit 0 (least significant) is bits [3:0].
- `dp_in` input, NUM_DIGITS: decimal-point request per digit, active-high.
- `lz_blank` input, 1: leading-zero blanking enable.
- `seg` output, 7: segment drive, active-low, in the same encoding as `BCD7Seg`.
- `dp` output, 1: decimal point, active-low.
- `an` output, NUM_DIGITS: anode select, active-low, one-hot or all-ones.
- `frame_done` output, 1: one-cycle pulse on every frame boundary.

## Operation

- Three-state FSM:
  - `IDLE`: all anodes off.
  - `BLANK`: anodes off, `seg`=7'h7F, `dp`=1, for `BLANK_CYCLES` cycles.
  - `DRIVE`: the anode of the current digit is on, for `REFRESH_DIV`−`BLANK_CYCLES` cycles.
- Transitions:
  - `IDLE`→`BLANK` (digit 0) when `en`=1.
  - `BLANK`→`DRIVE` when the slot counter reaches `BLANK_CYCLES`−1.
  - `DRIVE`→`BLANK` when the counter reaches `REFRESH_DIV`−1. The digit index advances, wrapping from `NUM_DIGITS`−1 to 0.
  - Any state→`IDLE` when `en`=0. The index and counter clear to 0.
- Buffering:
  - `load` writes the pending buffer and sets `pend_valid`. Back-to-back loads: last one wins.
  - At a frame boundary, if `pend_valid`=1, the active buffer takes the pending contents and `pend_valid` clears.
  - A frame boundary is either the last-digit `DRIVE`→`BLANK` transition or `IDLE`→`BLANK`.
  - `load` in the boundary cycle itself: the incoming value is applied at that boundary (bypass).
  - The active buffer never changes mid-frame.
- Leading-zero blanking:
  - With `lz_blank`=1, digit k is blanked when its nibble and every higher nibble are 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps its anode off and `dp` off during its `DRIVE` slot.
- Invalid nibble (>9): the decoder default is used, `seg`=7'h7F; the anode is still driven.
- `frame_done` pulses in the boundary cycle while `en`=1, whether or not a buffer swap occurs.

## Timing

- Reset values:
  - `an`: all 1s.
  - `seg`: 7'h7F.
  - `dp`: 1.
  - `frame_done`: 0.
  - Pending and active buffers: 0; `pend_valid`: 0.
  - FSM: `IDLE`; index and counter: 0.
- All outputs are registered: pins reflect the FSM state and index with a latency of 1 cycle.
- Slot length is exactly `REFRESH_DIV` cycles. Frame length is `NUM_DIGITS`×`REFRESH_DIV` cycles.
- Worst-case load-to-display latency: one frame plus one slot plus 1 cycle.
- `rst_n` asserted mid-`DRIVE`: outputs go to reset values immediately (asynchronous).
- `en` falling: anodes are off on the next clock edge.

## Structure

- Shared package holds:
  - FSM state encoding (`IDLE`, `BLANK`, `DRIVE`).
  - The blank-segment constant 7'h7F.
  - Active-low polarity constants for `an` and `dp`.
- Counter widths derive from `REFRESH_DIV` and `NUM_DIGITS` via `$clog2`.
- One sub-module: the existing `BCD7Seg`, instantiated once and fed by the active-buffer nibble at the current index.
- The leading-zero mask, the nibble mux and the FSM stay in this module.

## Test plan

All scenarios use `NUM_DIGITS`=4, `REFRESH_DIV`=8, `BLANK_CYCLES`=2.

1. Reset asserted with `en`=1 → `an`=4'b1111, `seg`=7'b1111111, `dp`=1, `frame_done`=0. After release, the first `BLANK` slot starts on digit 0.
2. `load` 16'h1234 then run 2 frames → digit 0 shows 2 blank cycles then 6 cycles of `an`=4'b1110, `seg`=7'b0011001. Digit 1 shows `an`=4'b1101, `seg`=7'b0110000. Digit 3 shows `seg`=7'b1111001.
3. `lz_blank`=1, `load` 16'h0070 → digits 3 and 2 keep `an` bit high for the full slot; digit 1 `seg`=7'b1111000; digit 0 `seg`=7'b1000000. Then `load` 16'h0000 → only digit 0 lit, showing 7'b1000000.
4. Nibble 4'hA on digit 2 with `dp_in`=4'b0100 → digit 2 anode on, `seg`=7'b1111111, `dp`=0.
5. `load` 16'h5555 mid-frame while showing 16'h1234 → remaining digits of that frame still show 1234. `frame_done` pulses once, then the next frame shows 5555. `load` in the boundary cycle itself takes effect in that frame.
6. `en` dropped mid-`DRIVE` → `an`=4'b1111 the next cycle. `en` re-raised → `BLANK` on digit 0 with `frame_done` pulse. `rst_n` pulsed mid-`DRIVE` → immediate reset values.
